// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Sequences one fully-connected layer pass. For each neuron n it
//            streams NUM_INPUTS (weight, input) pairs from external
//            synchronous-read memories, accumulates the products with signed
//            32-bit saturation, adds the neuron's bias (again saturating),
//            applies ReLU and emits the value with a one-cycle strobe.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - begin a layer pass (sampled in IDLE only)
//            busy, done      - pass in progress / one-cycle end-of-pass pulse
//            w_addr, w_data  - weight memory (data one cycle after address)
//            x_addr, x_data  - input vector memory (same latency)
//            b_addr, b_data  - bias memory (same latency)
//            result_valid    - strobe qualifying result / result_idx
//            result_idx      - neuron index of the emitted result
//            result          - ReLU(sat(sum + bias))
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] w_addr,
    input  logic [31:0] w_data,
    output logic [31:0] x_addr,
    input  logic [31:0] x_data,
    output logic [31:0] b_addr,
    input  logic [31:0] b_data,
    output logic        result_valid,
    output logic [31:0] result_idx,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] LAST_INPUT  = 32'(NUM_INPUTS - 1);
    localparam logic [31:0] LAST_NEURON = 32'(NUM_NEURONS - 1);

    state_t      state;
    logic [31:0] n;
    logic [31:0] i;
    logic [31:0] acc;
    // High in the cycle where memory data for an issued FETCH address is
    // present, so exactly NUM_INPUTS products reach the accumulator.
    logic        prod_valid;

    logic [31:0] product;
    logic [31:0] acc_next;
    logic [31:0] biased;

    // Signed saturating 32-bit add: overflow is detected on a 33-bit sum
    // whose top two bits disagree.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            sat_add = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            sat_add = s[31:0];
    endfunction

    always_comb begin
        // Low 32 bits of a product are identical for signed and unsigned
        // operands, so a plain 32-bit multiply is sufficient.
        product  = w_data * x_data;
        acc_next = sat_add(acc, product);
        biased   = sat_add(acc, b_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            n            <= 32'd0;
            i            <= 32'd0;
            acc          <= 32'd0;
            prod_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result       <= 32'd0;
            result_idx   <= 32'd0;
            w_addr       <= 32'd0;
            x_addr       <= 32'd0;
            b_addr       <= 32'd0;
        end else begin
            prod_valid   <= (state == FETCH);
            result_valid <= 1'b0;
            done         <= 1'b0;

            if (prod_valid)
                acc <= acc_next;

            case (state)
                IDLE: begin
                    if (start) begin
                        n      <= 32'd0;
                        i      <= 32'd0;
                        acc    <= 32'd0;
                        w_addr <= 32'd0;
                        x_addr <= 32'd0;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (i == LAST_INPUT) begin
                        b_addr <= n;
                        state  <= DRAIN;
                    end else begin
                        i      <= i + 32'd1;
                        w_addr <= w_addr + 32'd1;
                        x_addr <= x_addr + 32'd1;
                    end
                end
                DRAIN: begin
                    // Final product is accumulated via prod_valid this edge.
                    state <= BIAS;
                end
                BIAS: begin
                    result       <= biased[31] ? 32'd0 : biased;
                    result_idx   <= n;
                    result_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (n == LAST_NEURON) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        n      <= n + 32'd1;
                        i      <= 32'd0;
                        acc    <= 32'd0;
                        // Weight rows are contiguous: next row starts right
                        // after the last address issued.
                        w_addr <= w_addr + 32'd1;
                        x_addr <= 32'd0;
                        state  <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Purpose  : Self-checking bench for layer_sequencer (NUM_INPUTS=4,
//            NUM_NEURONS=2): table vectors with hand-derived results,
//            start/reset hazard sequences and random vectors against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int NI  = 4;
    localparam int NN  = 2;
    localparam int LAT = NI + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, result_valid;
    logic [31:0] w_addr, x_addr, b_addr;
    logic [31:0] w_data, x_data, b_data;
    logic [31:0] result_idx, result;

    layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .x_addr       (x_addr),
        .x_data       (x_data),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .result_valid (result_valid),
        .result_idx   (result_idx),
        .result       (result)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data follows the address by one cycle.
    logic [31:0] wmem [NI*NN];
    logic [31:0] xmem [NI];
    logic [31:0] bmem [NN];

    always @(posedge clk) begin
        w_data <= wmem[w_addr[2:0]];
        x_data <= xmem[x_addr[1:0]];
        b_data <= bmem[b_addr[0]];
    end

    typedef struct packed {
        logic [NI*NN-1:0][31:0] w;
        logic [NI-1:0][31:0]    x;
        logic [NN-1:0][31:0]    b;
        logic [NN-1:0][31:0]    exp_res;
    } vec_t;

    vec_t vecs [4];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < NI*NN; k++) wmem[k] = v.w[k];
        for (int k = 0; k < NI; k++)    xmem[k] = v.x[k];
        for (int k = 0; k < NN; k++)    bmem[k] = v.b[k];
    endtask

    function automatic longint clamp(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Reference: dot product with per-step saturation, saturated bias add, ReLU.
    function automatic logic [31:0] model(input int k);
        longint a, p;
        int     p32;
        a = 0;
        for (int j = 0; j < NI; j++) begin
            p   = longint'($signed(wmem[k*NI+j])) * longint'($signed(xmem[j]));
            p32 = int'(p);
            a   = clamp(a + longint'(p32));
        end
        a = clamp(a + longint'($signed(bmem[k])));
        return (a < 0) ? 32'd0 : 32'(a);
    endfunction

    // One full pass: start pulsed for one cycle, then every cycle checked
    // against the expected schedule. t counts edges after the sampling edge.
    task automatic run_pass(input logic [31:0] e0, input logic [31:0] e1, input bit hazard);
        logic [31:0] ex [NN];
        bit          ev, ed, eb;
        ex[0] = e0;
        ex[1] = e1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int t = 0; t < LAT*NN + 4; t++) begin
            if (t > 0) @(negedge clk);
            ev = ((t % LAT) == LAT-1) && (t < LAT*NN);
            ed = (t == LAT*NN);
            eb = (t <= LAT*NN);
            check("result_valid", {31'd0, result_valid}, {31'd0, ev});
            check("done", {31'd0, done}, {31'd0, ed});
            check("busy", {31'd0, busy}, {31'd0, eb});
            if (ev) begin
                check("result_idx", result_idx, 32'(t / LAT));
                check("result", result, ex[t / LAT]);
            end
            if (hazard) start = (t == 2);
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < NI*NN; k++) wmem[k] = 32'd0;
        for (int k = 0; k < NI; k++)    xmem[k] = 32'd0;
        for (int k = 0; k < NN; k++)    bmem[k] = 32'd0;

        // Basic pass: expected 10 and 20.
        for (int k = 0; k < NI; k++) begin
            vecs[0].w[k] = 32'd1; vecs[0].w[NI+k] = 32'd2; vecs[0].x[k] = 32'(k+1);
        end
        vecs[0].b = '0;
        vecs[0].exp_res[0] = 32'd10; vecs[0].exp_res[1] = 32'd20;
        // ReLU: -10+3 = -7 -> 0; neuron 1: 3*10+2 = 32.
        for (int k = 0; k < NI; k++) begin
            vecs[1].w[k] = 32'hFFFF_FFFF; vecs[1].w[NI+k] = 32'd3; vecs[1].x[k] = 32'(k+1);
        end
        vecs[1].b[0] = 32'd3; vecs[1].b[1] = 32'd2;
        vecs[1].exp_res[0] = 32'd0; vecs[1].exp_res[1] = 32'd32;
        // Accumulator saturation both directions; bias 5 does not escape.
        for (int k = 0; k < NI; k++) begin
            vecs[2].w[k] = 32'h7000_0000; vecs[2].w[NI+k] = 32'h9000_0000; vecs[2].x[k] = 32'd1;
        end
        vecs[2].b[0] = 32'd5; vecs[2].b[1] = 32'd5;
        vecs[2].exp_res[0] = 32'h7FFF_FFFF; vecs[2].exp_res[1] = 32'd0;
        // Bias saturation: 0x7FFFFFF0+0x100 clamps; 0+0x80000000 -> ReLU 0.
        for (int k = 0; k < NI; k++) begin
            vecs[3].w[k] = 32'h1FFF_FFFC; vecs[3].w[NI+k] = 32'd0; vecs[3].x[k] = 32'd1;
        end
        vecs[3].b[0] = 32'h0000_0100; vecs[3].b[1] = 32'h8000_0000;
        vecs[3].exp_res[0] = 32'h7FFF_FFFF; vecs[3].exp_res[1] = 32'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result_valid", {31'd0, result_valid}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst result_idx", result_idx, 32'd0);
        check("rst w_addr", w_addr, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load(vecs[v]);
            run_pass(vecs[v].exp_res[0], vecs[v].exp_res[1], 1'b0);
        end

        // result/result_idx hold after the pass.
        check("hold result", result, vecs[3].exp_res[1]);
        check("hold result_idx", result_idx, 32'd1);

        // start pulsed mid-FETCH has no effect.
        load(vecs[0]);
        run_pass(32'd10, 32'd20, 1'b1);

        // rst while FETCH: rst sampled at cycle-3 end edge.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin
            rst = 1'b0;
            check("mid rst busy", {31'd0, busy}, 32'd0);
            check("mid rst done", {31'd0, done}, 32'd0);
            check("mid rst result_valid", {31'd0, result_valid}, 32'd0);
            check("mid rst result", result, 32'd0);
            check("mid rst result_idx", result_idx, 32'd0);
            check("mid rst w_addr", w_addr, 32'd0);
            check("mid rst x_addr", x_addr, 32'd0);
            check("mid rst b_addr", b_addr, 32'd0);
        end
        for (int t = 0; t < 2*LAT*NN; t++) begin
            @(negedge clk);
            check("post rst result_valid", {31'd0, result_valid}, 32'd0);
            check("post rst done", {31'd0, done}, 32'd0);
        end
        run_pass(32'd10, 32'd20, 1'b0);

        // Random vectors: alternate small signed values and full-range values.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NI*NN; k++)
                wmem[k] = (r % 2) ? $urandom() : 32'($urandom_range(200, 0)) - 32'd100;
            for (int k = 0; k < NI; k++)
                xmem[k] = (r % 4 == 3) ? $urandom() : 32'($urandom_range(200, 0)) - 32'd100;
            for (int k = 0; k < NN; k++)
                bmem[k] = (r % 3 == 2) ? $urandom() : 32'($urandom_range(2000, 0)) - 32'd1000;
            run_pass(model(0), model(1), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
